// File: rtl/apb4_crc_master.sv
// APB4 initiator for a CRC peripheral: programs CTRL/INIT/XORV on a config request,
// then runs one write-DATA / poll-STAT / read-DATA job per streamed data word.
module apb4_crc_master #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int unsigned POLL_MAX  = 16
) (
   input  logic        apb4_pclk,
   input  logic        apb4_presetn,
   output logic [31:0] apb4_paddr,
   output logic [2:0]  apb4_pprot,
   output logic        apb4_psel,
   output logic        apb4_penable,
   output logic        apb4_pwrite,
   output logic [31:0] apb4_pwdata,
   output logic [3:0]  apb4_pstrb,
   input  logic        apb4_pready,
   input  logic [31:0] apb4_prdata,
   input  logic        apb4_pslverr,
   input  logic        cfg_valid_i,
   output logic        cfg_ready_o,
   input  logic [6:0]  cfg_ctrl_i,
   input  logic [31:0] cfg_init_i,
   input  logic [31:0] cfg_xorv_i,
   input  logic        data_valid_i,
   output logic        data_ready_o,
   input  logic [31:0] data_i,
   output logic        res_valid_o,
   input  logic        res_ready_i,
   output logic [31:0] res_data_o,
   output logic        res_err_o
);
   // state     | meaning
   // S_IDLE    | waiting for a config or data handshake
   // S_WR_CTRL | APB write of CTRL
   // S_WR_INIT | APB write of INIT
   // S_WR_XORV | APB write of XORV, marks config loaded
   // S_WR_DATA | APB write of the data word (restarts the slave CRC)
   // S_RD_STAT | APB read of STAT, repeated until done or poll limit
   // S_RD_DATA | APB read of the CRC result
   // S_RESP    | result held on res_* until consumed
   typedef enum logic [2:0] {
      S_IDLE, S_WR_CTRL, S_WR_INIT, S_WR_XORV, S_WR_DATA, S_RD_STAT, S_RD_DATA, S_RESP
   } state_t;

   typedef struct packed {
      logic        psel;
      logic        penable;
      logic        pwrite;
      logic [31:0] paddr;
      logic [31:0] pwdata;
      logic [3:0]  pstrb;
      logic        idle;
      logic        cfg_loaded;
      logic        err_acc;
      logic        word_err;
      logic [6:0]  ctrl;
      logic [31:0] init;
      logic [31:0] xorv;
      logic [15:0] poll_cnt;
      logic        res_valid;
      logic [31:0] res_data;
      logic        res_err;
   } regs_t;

   localparam logic [15:0] POLL_LIM = 16'(POLL_MAX);

   state_t      state, state_n;
   regs_t       r, r_n;
   logic        start;
   logic [15:0] poll_inc;
   logic [31:0] res_mask;

   assign poll_inc = (r.poll_cnt == 16'hFFFF) ? r.poll_cnt : r.poll_cnt + 16'd1;

   always_comb begin
      res_mask = 32'hFFFF_FFFF;
      case (r.ctrl[4:3])
         2'd0:    res_mask = 32'h0000_00FF;
         2'd1:    res_mask = 32'h0000_FFFF;
         2'd2:    res_mask = 32'h0000_FFFF;
         default: res_mask = 32'hFFFF_FFFF;
      endcase
   end

   always_ff @(posedge apb4_pclk or negedge apb4_presetn) begin
      if (!apb4_presetn) begin
         state <= S_IDLE;
         r     <= '0;
      end else begin
         state <= state_n;
         r     <= r_n;
      end
   end

   always_comb begin
      state_n = state;
      r_n     = r;
      start   = 1'b0;
      case (state)
         S_IDLE: begin
            if (cfg_valid_i && cfg_ready_o) begin
               r_n.ctrl    = cfg_ctrl_i;
               r_n.init    = cfg_init_i;
               r_n.xorv    = cfg_xorv_i;
               r_n.err_acc = 1'b0;
               state_n     = S_WR_CTRL;
               start       = 1'b1;
            end else if (data_valid_i && data_ready_o) begin
               r_n.poll_cnt = '0;
               r_n.word_err = 1'b0;
               state_n      = S_WR_DATA;
               start        = 1'b1;
            end
         end
         S_RESP: begin
            if (res_ready_i) begin
               r_n.res_valid = 1'b0;
               r_n.word_err  = 1'b0;
               state_n       = S_IDLE;
            end
         end
         default: begin
            if (!r.penable) begin
               r_n.penable = 1'b1;
            end else if (apb4_pready) begin
               r_n.psel    = 1'b0;
               r_n.penable = 1'b0;
               case (state)
                  S_WR_CTRL: begin
                     r_n.err_acc = r.err_acc | apb4_pslverr;
                     state_n     = S_WR_INIT;
                     start       = 1'b1;
                  end
                  S_WR_INIT: begin
                     r_n.err_acc = r.err_acc | apb4_pslverr;
                     state_n     = S_WR_XORV;
                     start       = 1'b1;
                  end
                  S_WR_XORV: begin
                     r_n.err_acc    = r.err_acc | apb4_pslverr;
                     r_n.cfg_loaded = 1'b1;
                     state_n        = S_IDLE;
                  end
                  S_WR_DATA: begin
                     r_n.word_err = r.word_err | apb4_pslverr;
                     state_n      = S_RD_STAT;
                     start        = 1'b1;
                  end
                  S_RD_STAT: begin
                     r_n.word_err = r.word_err | apb4_pslverr;
                     if (apb4_prdata[0]) begin
                        state_n = S_RD_DATA;
                        start   = 1'b1;
                     end else begin
                        r_n.poll_cnt = poll_inc;
                        if (poll_inc >= POLL_LIM) begin
                           r_n.res_data  = '0;
                           r_n.res_err   = 1'b1;
                           r_n.res_valid = 1'b1;
                           state_n       = S_RESP;
                        end else begin
                           start = 1'b1;
                        end
                     end
                  end
                  S_RD_DATA: begin
                     r_n.res_data  = apb4_prdata & res_mask;
                     r_n.res_err   = r.err_acc | r.word_err | apb4_pslverr;
                     r_n.res_valid = 1'b1;
                     state_n       = S_RESP;
                  end
                  default: ;
               endcase
            end
         end
      endcase

      // A new transfer always begins with a SETUP cycle on the next clock.
      if (start) begin
         r_n.psel    = 1'b1;
         r_n.penable = 1'b0;
         r_n.pwrite  = 1'b1;
         r_n.pstrb   = 4'hF;
         case (state_n)
            S_WR_CTRL: begin
               r_n.paddr  = BASE_ADDR + 32'h00;
               r_n.pwdata = {25'd0, cfg_ctrl_i};
            end
            S_WR_INIT: begin
               r_n.paddr  = BASE_ADDR + 32'h04;
               r_n.pwdata = r.init;
            end
            S_WR_XORV: begin
               r_n.paddr  = BASE_ADDR + 32'h08;
               r_n.pwdata = r.xorv;
            end
            S_WR_DATA: begin
               r_n.paddr  = BASE_ADDR + 32'h0C;
               r_n.pwdata = data_i;
            end
            S_RD_STAT: begin
               r_n.paddr  = BASE_ADDR + 32'h10;
               r_n.pwrite = 1'b0;
               r_n.pstrb  = 4'h0;
            end
            S_RD_DATA: begin
               r_n.paddr  = BASE_ADDR + 32'h0C;
               r_n.pwrite = 1'b0;
               r_n.pstrb  = 4'h0;
            end
            default: ;
         endcase
      end

      // Registered idle flag keeps the ready outputs low while in reset.
      r_n.idle = (state_n == S_IDLE);
   end

   assign apb4_paddr   = r.paddr;
   assign apb4_pprot   = 3'b000;
   assign apb4_psel    = r.psel;
   assign apb4_penable = r.penable;
   assign apb4_pwrite  = r.pwrite;
   assign apb4_pwdata  = r.pwdata;
   assign apb4_pstrb   = r.pstrb;
   assign cfg_ready_o  = r.idle;
   assign data_ready_o = r.idle & r.cfg_loaded & ~cfg_valid_i;
   assign res_valid_o  = r.res_valid;
   assign res_data_o   = r.res_data;
   assign res_err_o    = r.res_err;

endmodule

// File: tb/tb_apb4_crc_master.sv
// Bench for apb4_crc_master: APB slave model with wait states, poll and error control,
// transfer monitor, and a scoreboard of expected results per data word.
module tb_apb4_crc_master;
   localparam logic [31:0] A_CTRL = 32'h00;
   localparam logic [31:0] A_INIT = 32'h04;
   localparam logic [31:0] A_XORV = 32'h08;
   localparam logic [31:0] A_DATA = 32'h0C;
   localparam logic [31:0] A_STAT = 32'h10;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] paddr, pwdata, prdata;
   logic [2:0]  pprot;
   logic        psel, penable, pwrite, pready, pslverr;
   logic [3:0]  pstrb;
   logic        cfg_valid = 1'b0, cfg_ready;
   logic [6:0]  cfg_ctrl = '0;
   logic [31:0] cfg_init = '0, cfg_xorv = '0;
   logic        data_valid = 1'b0, data_ready;
   logic [31:0] data = '0;
   logic        res_valid, res_ready = 1'b1, res_err;
   logic [31:0] res_data;

   always #5 clk = ~clk;

   apb4_crc_master #(.BASE_ADDR(32'h0), .POLL_MAX(4)) dut (
      .apb4_pclk(clk), .apb4_presetn(rst_n),
      .apb4_paddr(paddr), .apb4_pprot(pprot), .apb4_psel(psel), .apb4_penable(penable),
      .apb4_pwrite(pwrite), .apb4_pwdata(pwdata), .apb4_pstrb(pstrb),
      .apb4_pready(pready), .apb4_prdata(prdata), .apb4_pslverr(pslverr),
      .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready), .cfg_ctrl_i(cfg_ctrl),
      .cfg_init_i(cfg_init), .cfg_xorv_i(cfg_xorv),
      .data_valid_i(data_valid), .data_ready_o(data_ready), .data_i(data),
      .res_valid_o(res_valid), .res_ready_i(res_ready), .res_data_o(res_data), .res_err_o(res_err)
   );

   // slave model controls
   int          n_wait = 0;
   int          done_after = 1;   // 0 = STAT never done
   logic [31:0] rd_val = '0;
   logic        err_en = 1'b0;
   logic [31:0] err_addr = '0;
   int          wait_cnt, spoll;

   assign pready  = psel & penable & (wait_cnt >= n_wait);
   assign pslverr = pready & err_en & (paddr == err_addr);

   always_comb begin
      prdata = '0;
      if (paddr == A_STAT) prdata[0] = (done_after != 0) && (spoll + 1 >= done_after);
      else if (paddr == A_DATA) prdata = rd_val;
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt <= 0;
         spoll    <= 0;
      end else if (psel && penable) begin
         if (pready) begin
            wait_cnt <= 0;
            if (!pwrite && paddr == A_STAT) spoll <= spoll + 1;
            if (pwrite && paddr == A_DATA) spoll <= 0;
         end else begin
            wait_cnt <= wait_cnt + 1;
         end
      end
   end

   // transfer monitor
   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          acc;
      logic        stable;
   } xfer_t;
   xfer_t xq[$];
   logic [31:0] su_addr, su_wdata;
   int          acc_n;
   logic        stab;

   always @(posedge clk) begin
      if (rst_n && psel) begin
         if (!penable) begin
            su_addr  <= paddr;
            su_wdata <= pwdata;
            acc_n    <= 0;
            stab     <= 1'b1;
         end else begin
            if (pready)
               xq.push_back('{pwrite, paddr, pwdata, acc_n + 1,
                              stab && paddr == su_addr && pwdata == su_wdata});
            acc_n <= acc_n + 1;
            stab  <= stab && paddr == su_addr && pwdata == su_wdata;
         end
      end
   end

   // scoreboard and checking
   typedef struct {
      logic [31:0] d;
      logic        e;
   } exp_t;
   exp_t sb[$];
   int   n_cmp = 0, n_bad = 0;
   logic [1:0] cur_mode = 2'd0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] exp_mask(input logic [1:0] m, input logic [31:0] v);
      case (m)
         2'd0:    return v & 32'h0000_00FF;
         2'd3:    return v;
         default: return v & 32'h0000_FFFF;
      endcase
   endfunction

   task automatic chk_xfer(input int idx, input logic wr, input logic [31:0] a, input logic [31:0] wd);
      if (idx < xq.size()) begin
         check_eq($sformatf("xfer%0d_wr", idx), xq[idx].wr, wr);
         check_eq($sformatf("xfer%0d_addr", idx), xq[idx].addr, a);
         if (wr) check_eq($sformatf("xfer%0d_wdata", idx), xq[idx].wdata, wd);
      end else begin
         check_eq($sformatf("xfer%0d_present", idx), xq.size(), idx + 1);
      end
   endtask

   function automatic int count_rd(input logic [31:0] a);
      int n = 0;
      foreach (xq[i]) if (!xq[i].wr && xq[i].addr == a) n++;
      return n;
   endfunction

   task automatic do_cfg(input logic [6:0] c, input logic [31:0] i, input logic [31:0] x);
      int t = 0;
      @(negedge clk);
      cfg_valid = 1'b1; cfg_ctrl = c; cfg_init = i; cfg_xorv = x;
      while (!cfg_ready && t < 200) begin @(negedge clk); t++; end
      check_eq("cfg_accept", cfg_ready, 1);
      @(posedge clk);
      @(negedge clk);
      cfg_valid = 1'b0;
      cur_mode = c[4:3];
      t = 0;
      while (!cfg_ready && t < 400) begin @(negedge clk); t++; end
      check_eq("cfg_done", cfg_ready, 1);
   endtask

   task automatic get_result(input string tag);
      exp_t e;
      check_eq({tag, "_valid"}, res_valid, 1);
      if (sb.size() == 0) begin
         check_eq({tag, "_sb_entry"}, sb.size(), 1);
      end else begin
         e = sb.pop_front();
         check_eq({tag, "_data"}, res_data, e.d);
         check_eq({tag, "_err"}, res_err, e.e);
      end
   endtask

   task automatic do_word(input string tag, input logic [31:0] d, input logic [31:0] ed,
                          input logic ee, output int lat);
      int t = 0;
      @(negedge clk);
      data_valid = 1'b1; data = d;
      sb.push_back('{ed, ee});
      while (!data_ready && t < 200) begin @(negedge clk); t++; end
      check_eq({tag, "_accept"}, data_ready, 1);
      @(posedge clk);
      @(negedge clk);
      data_valid = 1'b0;
      lat = 0;
      while (!res_valid && lat < 400) begin @(negedge clk); lat++; end
      get_result(tag);
      @(posedge clk);
   endtask

   int lat;
   int t;

   initial begin
      repeat (3) @(negedge clk);
      check_eq("rst_psel", psel, 0);
      check_eq("rst_penable", penable, 0);
      check_eq("rst_pwrite", pwrite, 0);
      check_eq("rst_paddr", paddr, 0);
      check_eq("rst_pwdata", pwdata, 0);
      check_eq("rst_pstrb", pstrb, 0);
      check_eq("rst_cfg_ready", cfg_ready, 0);
      check_eq("rst_data_ready", data_ready, 0);
      check_eq("rst_res_valid", res_valid, 0);
      check_eq("rst_res_data", res_data, 0);
      check_eq("rst_res_err", res_err, 0);
      check_eq("pprot", pprot, 0);
      rst_n = 1'b1;

      // reset during the ACCESS phase of the INIT write
      n_wait = 2;
      @(negedge clk);
      cfg_valid = 1'b1; cfg_ctrl = 7'h01; cfg_init = 32'h1111_1111; cfg_xorv = 32'h0;
      t = 0;
      while (!cfg_ready && t < 50) begin @(negedge clk); t++; end
      check_eq("mid_cfg_accept", cfg_ready, 1);
      @(posedge clk);
      @(negedge clk);
      cfg_valid = 1'b0;
      t = 0;
      while (!(psel && penable && paddr == A_INIT) && t < 50) begin @(negedge clk); t++; end
      check_eq("mid_init_access", {31'd0, psel && penable && paddr == A_INIT}, 1);
      #1 rst_n = 1'b0;
      #1;
      check_eq("mid_rst_psel", psel, 0);
      check_eq("mid_rst_penable", penable, 0);
      check_eq("mid_rst_paddr", paddr, 0);
      @(negedge clk);
      rst_n = 1'b1;
      data_valid = 1'b1; data = 32'h1;
      repeat (5) begin
         @(negedge clk);
         check_eq("mid_rst_data_ready", data_ready, 0);
      end
      data_valid = 1'b0;
      xq.delete();

      // CRC8 job, best-case timing
      n_wait = 0; done_after = 1;
      do_cfg(7'h01, 32'h0, 32'h0);
      rd_val = 32'hFFFF_FF07;
      do_word("crc8", 32'h1, exp_mask(cur_mode, rd_val), 1'b0, lat);
      check_eq("lat_best", lat, 6);
      check_eq("crc8_nxfer", xq.size(), 6);
      chk_xfer(0, 1'b1, A_CTRL, 32'h01);
      chk_xfer(1, 1'b1, A_INIT, 32'h0);
      chk_xfer(2, 1'b1, A_XORV, 32'h0);
      chk_xfer(3, 1'b1, A_DATA, 32'h01);
      chk_xfer(4, 1'b0, A_STAT, 32'h0);
      chk_xfer(5, 1'b0, A_DATA, 32'h0);

      // CRC32 and CRC16 masking
      xq.delete();
      do_cfg(7'h79, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      chk_xfer(0, 1'b1, A_CTRL, 32'h79);
      chk_xfer(1, 1'b1, A_INIT, 32'hFFFF_FFFF);
      chk_xfer(2, 1'b1, A_XORV, 32'hFFFF_FFFF);
      rd_val = 32'hDEAD_BEEF;
      do_word("crc32", 32'hA5A5_0001, 32'hDEAD_BEEF, 1'b0, lat);
      do_cfg(7'h29, 32'h0000_FFFF, 32'h0);
      do_word("crc16", 32'h0000_1234, 32'h0000_BEEF, 1'b0, lat);

      // three wait states per transfer
      n_wait = 3;
      xq.delete();
      do_word("wait3", 32'h0000_0055, 32'h0000_BEEF, 1'b0, lat);
      check_eq("wait3_lat", lat, 15);
      check_eq("wait3_nxfer", xq.size(), 3);
      foreach (xq[i]) begin
         check_eq($sformatf("wait3_acc%0d", i), xq[i].acc, 4);
         check_eq($sformatf("wait3_stable%0d", i), xq[i].stable, 1);
      end

      // done on third poll
      n_wait = 0; done_after = 3;
      xq.delete();
      do_word("poll3", 32'h0000_0066, 32'h0000_BEEF, 1'b0, lat);
      check_eq("poll3_stat_reads", count_rd(A_STAT), 3);

      // poll timeout
      done_after = 0;
      xq.delete();
      do_word("tmo", 32'h0000_0077, 32'h0, 1'b1, lat);
      check_eq("tmo_stat_reads", count_rd(A_STAT), 4);
      check_eq("tmo_data_reads", count_rd(A_DATA), 0);
      done_after = 1;

      // simultaneous config and data, then a stalled consumer
      @(negedge clk);
      cfg_valid = 1'b1; cfg_ctrl = 7'h79; cfg_init = 32'hFFFF_FFFF; cfg_xorv = 32'h0;
      data_valid = 1'b1; data = 32'h0000_0088;
      #1;
      check_eq("prio_data_ready", data_ready, 0);
      check_eq("prio_cfg_ready", cfg_ready, 1);
      cur_mode = 2'd3;
      rd_val = 32'h1234_5678;
      res_ready = 1'b0;
      sb.push_back('{32'h1234_5678, 1'b0});
      @(posedge clk);
      @(negedge clk);
      cfg_valid = 1'b0;
      t = 0;
      while (!data_ready && t < 200) begin @(negedge clk); t++; end
      check_eq("prio_data_accept", data_ready, 1);
      @(posedge clk);
      @(negedge clk);
      data_valid = 1'b0;
      t = 0;
      while (!res_valid && t < 200) begin @(negedge clk); t++; end
      repeat (5) begin
         @(negedge clk);
         check_eq("hold_valid", res_valid, 1);
         check_eq("hold_data", res_data, 32'h1234_5678);
         check_eq("hold_psel", psel, 0);
      end
      get_result("hold");
      res_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_eq("hold_release", res_valid, 0);

      // slave errors: per-word error clears, config error persists until reconfig
      err_addr = A_DATA; err_en = 1'b1;
      do_word("err_data", 32'h1, 32'h1234_5678, 1'b1, lat);
      err_en = 1'b0;
      do_word("err_clear", 32'h2, 32'h1234_5678, 1'b0, lat);
      err_addr = A_CTRL; err_en = 1'b1;
      do_cfg(7'h01, 32'h0, 32'h0);
      err_en = 1'b0;
      do_word("err_cfg1", 32'h3, 32'h0000_0078, 1'b1, lat);
      do_word("err_cfg2", 32'h4, 32'h0000_0078, 1'b1, lat);
      do_cfg(7'h01, 32'h0, 32'h0);
      do_word("err_recfg", 32'h5, 32'h0000_0078, 1'b0, lat);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got stuck expected completion");
      $fatal(1);
   end

endmodule
